vend_dispense_ctrl: RTL

- Consumer side of the vending FSM's `out`/`change` outputs.
- Buffers each vend and change request, then runs the physical actuators: the product motor and a 5rs coin hopper.
- Closes each actuation with a sense/done handshake and a timeout.
- Sits between the vending state machine and the mechanism drivers.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_req_fifo.sv | 55 +++++
 rtl/vend_dispense_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the dispense controller.
//   - coin-code constants as driven on change_req
//   - FSM state encoding
//   - request FIFO entry layout and the change-code -> coin-count decode
package vend_pkg;

  localparam logic [1:0] NO_COIN = 2'b00;
  localparam logic [1:0] COIN5   = 2'b01;
  localparam logic [1:0] COIN10  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_VEND       = 3'd1,
    S_COIN_PULSE = 3'd2,
    S_COIN_WAIT  = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  // One queued request: dispense a product and/or eject 0..2 5rs coins.
  typedef struct packed {
    logic       vend;
    logic [1:0] coins;
  } req_t;

  // 10rs change is paid as two 5rs coins; the illegal code pays nothing.
  function automatic logic [1:0] coins_of(input logic [1:0] code);
    case (code)
      COIN5:   coins_of = 2'd1;
      COIN10:  coins_of = 2'd2;
      default: coins_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// vend_req_fifo: synchronous request FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request; ignored when full unless a pop happens too
//   pop, dout  : read request / head entry (dout valid while !empty)
//   full, empty: occupancy flags
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t din,
  input  logic pop,
  output req_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  req_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: buffers vend/change requests from the vending FSM and
// drives the product motor and the 5rs coin hopper, closing each actuation
// with its sense handshake and a timeout.
//   clk, rst      : clock, synchronous active-high reset
//   vend_req      : dispense request
//   change_req    : 00 none, 01 5rs, 10 10rs, 11 illegal (no coins)
//   motor_done    : product drop sensed
//   coin_sense    : one coin ejected (single-cycle)
//   motor_en      : product motor drive (registered)
//   hopper_pulse  : coin eject strobe (registered)
//   busy          : FSM active or requests queued
//   overflow      : sticky, a request was dropped on a full FIFO
//   fault         : sticky, actuator timeout (cleared only by rst)
//   vend_count    : completed vends, wraps
//   coin_count    : coins ejected, saturates
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int MOTOR_TIMEOUT  = 16,
  parameter int HOPPER_TIMEOUT = 8,
  parameter int PULSE_LEN      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] change_req,
  input  logic       motor_done,
  input  logic       coin_sense,
  output logic       motor_en,
  output logic       hopper_pulse,
  output logic       busy,
  output logic       overflow,
  output logic       fault,
  output logic [7:0] vend_count,
  output logic [7:0] coin_count
);

  localparam int TMAX = (MOTOR_TIMEOUT > HOPPER_TIMEOUT)
                      ? ((MOTOR_TIMEOUT > PULSE_LEN) ? MOTOR_TIMEOUT : PULSE_LEN)
                      : ((HOPPER_TIMEOUT > PULSE_LEN) ? HOPPER_TIMEOUT : PULSE_LEN);
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state, nxt;
  logic [TW-1:0] tmr;
  logic [1:0]    remaining;
  req_t          push_req, head;
  logic          push, pop, full, empty;
  logic          coin_ok;

  always_comb begin
    push_req       = '0;
    push_req.vend  = vend_req;
    push_req.coins = coins_of(change_req);
  end

  assign push    = push_req.vend || (push_req.coins != 2'd0);
  assign pop     = (state == S_IDLE) && !empty;
  assign coin_ok = (state == S_COIN_WAIT) && coin_sense;

  vend_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_req),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (!empty) nxt = head.vend ? S_VEND : S_COIN_PULSE;
      S_VEND:
        if (motor_done)                           nxt = (remaining != 2'd0) ? S_COIN_PULSE : S_IDLE;
        else if (tmr == TW'(MOTOR_TIMEOUT - 1))   nxt = S_FAULT;
      S_COIN_PULSE:
        if (tmr == TW'(PULSE_LEN - 1))            nxt = S_COIN_WAIT;
      S_COIN_WAIT:
        // remaining is decremented on this sense, so 1 means last coin.
        if (coin_sense)                           nxt = (remaining != 2'd1) ? S_COIN_PULSE : S_IDLE;
        else if (tmr == TW'(HOPPER_TIMEOUT - 1))  nxt = S_FAULT;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tmr          <= '0;
      remaining    <= '0;
      motor_en     <= 1'b0;
      hopper_pulse <= 1'b0;
      overflow     <= 1'b0;
      vend_count   <= '0;
      coin_count   <= '0;
    end else begin
      state <= nxt;
      // Per-state cycle counter, restarted on every state entry.
      if (nxt != state || state == S_IDLE || state == S_FAULT) tmr <= '0;
      else                                                      tmr <= tmr + 1'b1;

      if (pop)          remaining <= head.coins;
      else if (coin_ok) remaining <= remaining - 2'd1;

      // Motor drops in the same edge that leaves VEND (done or timeout),
      // so it is never on in FAULT and stops as soon as the drop is sensed.
      motor_en     <= (state == S_VEND) && (nxt == S_VEND);
      hopper_pulse <= (state == S_COIN_PULSE);

      if (push && full && !pop) overflow <= 1'b1;

      if (state == S_VEND && motor_done) vend_count <= vend_count + 8'd1;
      if (coin_ok && coin_count != 8'hFF) coin_count <= coin_count + 8'd1;
    end
  end

  assign fault = (state == S_FAULT);
  assign busy  = (state != S_IDLE) || !empty;

endmodule
